// File: rtl/inp_buf_pkg.sv
// inp_buf_pkg: shared constants, replay command encoding and pointer-width helper
package inp_buf_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int LANES_DEF = 4;
    localparam int DEPTH_DEF = 32;
    typedef enum logic [1:0] {CMD_NONE, CMD_MARK, CMD_REL, CMD_REWIND} replay_cmd_e;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/inp_fifo_replay_if.sv
// inp_fifo_replay_if: producer/consumer valid-ready handshake bundle of the input FIFO
interface inp_fifo_replay_if #(parameter int W = 32);
    logic in_valid;
    logic in_ready;
    logic [W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [W-1:0] out_data;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/inp_buf_mem.sv
// inp_buf_mem: entry storage with one synchronous write port and one asynchronous read port
module inp_buf_mem #(
    parameter int W = 32,
    parameter int DEPTH = 32
) (
    input  logic sys_clk,
    input  logic we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge sys_clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/inp_fifo_replay.sv
// inp_fifo_replay: multi-lane input FIFO with mark/rewind replay for sliding-window reuse
module inp_fifo_replay
    import inp_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES = LANES_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    inp_fifo_replay_if.slave bus,
    input  logic mark,
    input  logic rewind,
    input  logic rel,
    output logic [ptr_w(DEPTH)-1:0] count,
    output logic full,
    output logic almost_full,
    output logic mark_active,
    output logic err
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int W = LANES * DATA_W;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P = PW'(AF_THRESH);

    logic [PW-1:0] wr, rd, mk, cnt, occ, rd_nx, mk_nx;
    logic mark_q, err_q, mark_nx, err_nx, push, pop;
    logic [W-1:0] rd_data;
    replay_cmd_e cmd;

    // while marked, space is measured from the replay base so popped entries stay protected
    assign cnt = wr - rd;
    assign occ = wr - (mark_q ? mk : rd);
    assign full = rst_n & (occ == DEPTH_P);
    assign almost_full = rst_n & (occ >= AF_P);
    assign count = rst_n ? cnt : '0;
    assign mark_active = rst_n & mark_q;
    assign err = rst_n & err_q;

    assign bus.in_ready = rst_n & en & ~full;
    assign bus.out_valid = rst_n & en & (cnt != '0);
    assign bus.out_data = (rst_n && cnt != '0) ? rd_data : '0;
    assign push = bus.in_valid & bus.in_ready;
    assign pop = bus.out_valid & bus.out_ready & ~rewind;

    assign cmd = rewind ? CMD_REWIND : rel ? CMD_REL : mark ? CMD_MARK : CMD_NONE;
    always_comb begin
        rd_nx = (cmd == CMD_REWIND && mark_q) ? mk : rd + PW'(pop);
        mk_nx = (cmd == CMD_MARK) ? rd + PW'(pop) : mk;
        mark_nx = (cmd == CMD_MARK) || (mark_q && cmd != CMD_REL);
        err_nx = err_q || (cmd == CMD_REWIND && !mark_q);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n || (en && clr)) begin
            wr <= '0;
            rd <= '0;
            mk <= '0;
            mark_q <= 1'b0;
            err_q <= 1'b0;
        end else if (en) begin
            wr <= wr + PW'(push);
            rd <= rd_nx;
            mk <= mk_nx;
            mark_q <= mark_nx;
            err_q <= err_nx;
        end
    end

    inp_buf_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
        .sys_clk(sys_clk),
        .we(push),
        .waddr(wr[AW-1:0]),
        .wdata(bus.in_data),
        .raddr(rd[AW-1:0]),
        .rdata(rd_data)
    );
endmodule

// File: tb/tb_inp_fifo_replay.sv
// tb_inp_fifo_replay: scoreboard bench for the replay input FIFO (DEPTH=32, LANES=1)
module tb_inp_fifo_replay;
    localparam int DW = 8;
    localparam int LN = 1;
    localparam int DP = 32;
    localparam int AF = 28;
    localparam int W = DW * LN;

    logic sys_clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic mark = 1'b0;
    logic rewind = 1'b0;
    logic rel = 1'b0;
    logic [5:0] count;
    logic full, almost_full, mark_active, err;
    logic [W-1:0] q[$];
    logic [W-1:0] rq[$];
    bit sb_mark;
    int n_cmp = 0;
    int n_fail = 0;

    inp_fifo_replay_if #(.W(W)) bus ();

    inp_fifo_replay #(.DATA_W(DW), .LANES(LN), .DEPTH(DP), .AF_THRESH(AF)) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .en(en),
        .clr(clr),
        .bus(bus),
        .mark(mark),
        .rewind(rewind),
        .rel(rel),
        .count(count),
        .full(full),
        .almost_full(almost_full),
        .mark_active(mark_active),
        .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: expected entries queued on accepted pushes, checked on accepted pops
    initial begin
        logic [W-1:0] e_data;
        forever begin
            @(negedge sys_clk);
            if (!rst_n || (en && clr)) begin
                q.delete();
                rq.delete();
                sb_mark = 1'b0;
            end else if (en) begin
                if (bus.out_valid && bus.out_ready && !rewind) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_pop: got %0h with nothing expected", bus.out_data);
                    end else begin
                        e_data = q.pop_front();
                        if (bus.out_data !== e_data) begin
                            n_fail++;
                            $display("FAIL sb_data: got %0h want %0h", bus.out_data, e_data);
                        end
                        if (sb_mark) rq.push_back(e_data);
                    end
                end
                if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
                if (rewind) begin
                    if (sb_mark) begin
                        q = {rq, q};
                        rq.delete();
                    end
                end else if (rel) begin
                    sb_mark = 1'b0;
                    rq.delete();
                end else if (mark) begin
                    sb_mark = 1'b1;
                    rq.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base);
        bus.in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_data = W'(base + i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.out_ready = 1'b1;
        repeat (n) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, full, almost_full, mark_active, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.in_ready, bus.out_valid, full, almost_full, mark_active, err});
        end
        n_cmp++;
        if (count !== 6'd0 || bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_count_data: got %0d/%0h want 0/0", count, bus.out_data);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_fill_drain();
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            bus.in_data = W'(k);
            tick();
            n_cmp++;
            if (almost_full !== (k >= AF) || full !== (k == DP)) begin
                n_fail++;
                $display("FAIL fill_flags k=%0d: got af=%b full=%b want af=%b full=%b",
                         k, almost_full, full, k >= AF, k == DP);
            end
        end
        n_cmp++;
        if (count !== 6'd32 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got count=%0d rdy=%b want 32/0", count, bus.in_ready);
        end
        bus.in_data = 8'hEE;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (count !== 6'd32) begin
            n_fail++;
            $display("FAIL fill_overflow: got count=%0d want 32", count);
        end
        pop_n(32);
        n_cmp++;
        if (count !== 6'd0 || bus.out_data !== 8'h00 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got count=%0d data=%0h full=%b want 0/0/0", count, bus.out_data, full);
        end
    endtask

    task automatic test_back_to_back();
        push_n(3, 8'h60);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_data = W'(8'h80 + i);
            tick();
            n_cmp++;
            if (count !== 6'd3) begin
                n_fail++;
                $display("FAIL stream_count i=%0d: got %0d want 3", i, count);
            end
        end
        bus.in_valid = 1'b0;
        pop_n(3);
        n_cmp++;
        if (count !== 6'd0) begin
            n_fail++;
            $display("FAIL stream_drain: got %0d want 0", count);
        end
    endtask

    task automatic test_replay();
        push_n(8, 8'h10);
        mark = 1'b1;
        tick();
        mark = 1'b0;
        n_cmp++;
        if (mark_active !== 1'b1) begin
            n_fail++;
            $display("FAIL replay_mark: got %b want 1", mark_active);
        end
        pop_n(5);
        n_cmp++;
        if (count !== 6'd3) begin
            n_fail++;
            $display("FAIL replay_pop5: got %0d want 3", count);
        end
        rewind = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rewind = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (count !== 6'd8 || bus.out_data !== 8'h10) begin
            n_fail++;
            $display("FAIL replay_rewind: got count=%0d data=%0h want 8/10", count, bus.out_data);
        end
        pop_n(8);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        n_cmp++;
        if (mark_active !== 1'b0 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL replay_release: got mark=%b count=%0d want 0/0", mark_active, count);
        end
    endtask

    task automatic test_full_marked();
        mark = 1'b1;
        tick();
        mark = 1'b0;
        push_n(10, 100);
        pop_n(10);
        push_n(22, 200);
        n_cmp++;
        if (full !== 1'b1 || almost_full !== 1'b1 || bus.in_ready !== 1'b0 || count !== 6'd22) begin
            n_fail++;
            $display("FAIL marked_full: got full=%b af=%b rdy=%b count=%0d want 1/1/0/22",
                     full, almost_full, bus.in_ready, count);
        end
        push_n(1, 8'hEE);
        n_cmp++;
        if (count !== 6'd22) begin
            n_fail++;
            $display("FAIL marked_overflow: got %0d want 22", count);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        n_cmp++;
        if (full !== 1'b0 || bus.in_ready !== 1'b1 || almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL marked_release: got full=%b rdy=%b af=%b want 0/1/0", full, bus.in_ready, almost_full);
        end
        pop_n(22);
        n_cmp++;
        if (count !== 6'd0) begin
            n_fail++;
            $display("FAIL marked_drain: got %0d want 0", count);
        end
    endtask

    task automatic test_err_clr();
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL err_set: got err=%b count=%0d want 1/0", err, count);
        end
        bus.out_ready = 1'b1;
        push_n(3, 8'h30);
        pop_n(1);
        n_cmp++;
        if (err !== 1'b1 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b count=%0d want 1/0", err, count);
        end
        push_n(2, 8'h40);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || count !== 6'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr: got err=%b count=%0d vld=%b want 0/0/0", err, count, bus.out_valid);
        end
    endtask

    task automatic test_midstream_reset();
        push_n(4, 8'h70);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, full, almost_full, mark_active, err} !== 6'b0
            || count !== 6'd0 || bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_outputs: got flags=%b count=%0d data=%0h want 0/0/0",
                     {bus.in_ready, bus.out_valid, full, almost_full, mark_active, err}, count, bus.out_data);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (count !== 6'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after: got count=%0d vld=%b rdy=%b want 0/0/1", count, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_enable_low();
        push_n(5, 8'h50);
        en = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (count !== 6'd5 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h50) begin
                n_fail++;
                $display("FAIL en_low i=%0d: got count=%0d rdy=%b vld=%b data=%0h want 5/0/0/50",
                         i, count, bus.in_ready, bus.out_valid, bus.out_data);
            end
        end
        bus.in_valid = 1'b0;
        en = 1'b1;
        pop_n(5);
        n_cmp++;
        if (count !== 6'd0) begin
            n_fail++;
            $display("FAIL en_drain: got %0d want 0", count);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_replay();
        test_full_marked();
        test_err_clr();
        test_midstream_reset();
        test_enable_low();
        tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
